// File: rtl/mdu_seq.sv
// Multi-cycle MULTU/DIVU sequencer that borrows the shared alu one step per cycle and owns HI/LO.
// Optional signed support (MULT/DIV via magnitudes plus a final FIX step) enabled by `define MDU_SIGNED_EN.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_op,
    input  logic             i_op_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_alu_req,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [3:0]       o_alu_ctrl,
    input  logic [WIDTH-1:0] i_alu_dout
);
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [3:0] C_ADDU = 4'b0000;
    localparam logic [3:0] C_SUBU = 4'b0001;
    localparam logic [3:0] C_LT   = 4'b0110;
    localparam logic [3:0] C_AA   = 4'b0100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DCMP = 3'd2,
        S_DSUB = 3'd3,
        S_FIN  = 3'd4
`ifdef MDU_SIGNED_EN
        , S_FIX = 3'd5
`endif
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_iter;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_wh;     // P_hi (mul) / remainder R (div)
    logic [WIDTH-1:0] r_wl;     // P_lo (mul) / quotient Q (div)
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_rsh;
    logic             w_qbit;
    logic             w_carry;
    logic             w_last;
    logic             w_busy;
    state_t           w_post;

`ifdef MDU_SIGNED_EN
    logic r_sgn;
    logic r_op;
    logic r_sa;
    logic r_sb;

    assign w_a_mag = (i_op_signed && i_a[WIDTH-1]) ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = (i_op_signed && i_b[WIDTH-1]) ? (~i_b + 1'b1) : i_b;
    assign w_post  = r_sgn ? S_FIX : S_FIN;
`else
    logic w_unused_sgn;

    assign w_unused_sgn = i_op_signed;
    assign w_a_mag      = i_a;
    assign w_b_mag      = i_b;
    assign w_post       = S_FIN;
`endif

    // Divide step: shifted remainder, with the bit shifted out acting as the 33rd bit.
    assign w_rsh   = {r_wh[WIDTH-2:0], r_wl[WIDTH-1]};
    assign w_qbit  = r_wh[WIDTH-1] | (i_alu_dout == '0);
    assign w_carry = (i_alu_dout < r_wh);
    assign w_last  = (r_iter == IW'(ITER - 1));

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_MUL, S_DCMP, S_DSUB: w_busy = 1'b1;
`ifdef MDU_SIGNED_EN
            S_FIX:                 w_busy = 1'b1;
`endif
            default:               w_busy = 1'b0;
        endcase
    end

    always_comb begin
        o_alu_a    = '0;
        o_alu_b    = '0;
        o_alu_ctrl = C_AA;
        case (r_state)
            S_MUL: begin
                o_alu_a    = r_wh;
                o_alu_b    = r_b;
                o_alu_ctrl = C_ADDU;
            end
            S_DCMP: begin
                o_alu_a    = w_rsh;
                o_alu_b    = r_b;
                o_alu_ctrl = C_LT;
            end
            S_DSUB: begin
                o_alu_a    = r_wh;
                o_alu_b    = r_b;
                o_alu_ctrl = C_SUBU;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
            r_b     <= '0;
            r_wh    <= '0;
            r_wl    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
`ifdef MDU_SIGNED_EN
            r_sgn   <= 1'b0;
            r_op    <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_hi_we) r_hi <= i_wdata;
                    if (i_lo_we) r_lo <= i_wdata;
                    if (i_start) begin
                        r_iter <= '0;
                        r_b    <= w_b_mag;
`ifdef MDU_SIGNED_EN
                        r_sgn  <= i_op_signed;
                        r_op   <= i_op;
                        r_sa   <= i_op_signed & i_a[WIDTH-1];
                        r_sb   <= i_op_signed & i_b[WIDTH-1];
`endif
                        if (!i_op || (i_b != '0)) begin
                            r_wh    <= '0;
                            r_wl    <= w_a_mag;
                            r_state <= i_op ? S_DCMP : S_MUL;
                        end else begin
                            // Divide by zero: architectural result straight from the raw dividend.
                            r_wh    <= i_a;
                            r_wl    <= '1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_MUL: begin
                    if (r_wl[0]) begin
                        r_wh <= {w_carry, i_alu_dout[WIDTH-1:1]};
                        r_wl <= {i_alu_dout[0], r_wl[WIDTH-1:1]};
                    end else begin
                        r_wh <= {1'b0, r_wh[WIDTH-1:1]};
                        r_wl <= {r_wh[0], r_wl[WIDTH-1:1]};
                    end
                    r_iter <= r_iter + 1'b1;
                    if (w_last) r_state <= w_post;
                end
                S_DCMP: begin
                    r_wh    <= w_rsh;
                    r_wl    <= {r_wl[WIDTH-2:0], w_qbit};
                    r_state <= S_DSUB;
                end
                S_DSUB: begin
                    // Always spent, even when no subtract is due, so divide latency is fixed.
                    if (r_wl[0]) r_wh <= i_alu_dout;
                    r_iter  <= r_iter + 1'b1;
                    r_state <= w_last ? w_post : S_DCMP;
                end
`ifdef MDU_SIGNED_EN
                S_FIX: begin
                    if (!r_op) begin
                        if (r_sa ^ r_sb) {r_wh, r_wl} <= ~{r_wh, r_wl} + 1'b1;
                    end else begin
                        if (r_sa ^ r_sb) r_wl <= ~r_wl + 1'b1;
                        if (r_sa)        r_wh <= ~r_wh + 1'b1;
                    end
                    r_state <= S_FIN;
                end
`endif
                S_FIN: begin
                    r_hi    <= r_wh;
                    r_lo    <= r_wl;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy    = w_busy;
    assign o_alu_req = w_busy;
    assign o_done    = r_done;
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: random and directed MULTU/DIVU against a plain-arithmetic model.
// Signed expectations follow `define MDU_SIGNED_EN, matching the build of the design.
module tb_mdu_seq;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_op = 1'b0;
    logic        i_op_signed = 1'b0;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        i_hi_we = 1'b0;
    logic        i_lo_we = 1'b0;
    logic [31:0] i_wdata = '0;
    logic        o_busy, o_done, o_alu_req;
    logic [31:0] o_hi, o_lo, o_alu_a, o_alu_b;
    logic [3:0]  o_alu_ctrl;
    logic [31:0] i_alu_dout;

`ifdef MDU_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    mdu_seq #(.WIDTH(32), .ITER(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op),
        .i_op_signed(i_op_signed), .i_a(i_a), .i_b(i_b), .i_hi_we(i_hi_we),
        .i_lo_we(i_lo_we), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
        .o_hi(o_hi), .o_lo(o_lo), .o_alu_req(o_alu_req), .o_alu_a(o_alu_a),
        .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl), .i_alu_dout(i_alu_dout)
    );

    always #5 i_clk = ~i_clk;

    // Shared alu as seen by the datapath.
    always_comb begin
        case (o_alu_ctrl)
            4'b0000: i_alu_dout = o_alu_a + o_alu_b;
            4'b0001: i_alu_dout = o_alu_a - o_alu_b;
            4'b0110: i_alu_dout = {31'b0, (o_alu_a < o_alu_b)};
            default: i_alu_dout = o_alu_a;
        endcase
    end

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void model(input bit op, input bit sgn, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo, output int lat);
        bit          s;
        longint      sa, sbv, p, q, r;
        logic [63:0] u;
        s = sgn & SIGNED_EN;
        if (op && b == 0) begin
            hi = a; lo = 32'hFFFF_FFFF; lat = 1;
            return;
        end
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (!op) begin
            if (s) begin p = sa * sbv; {hi, lo} = p; end
            else   begin u = {32'b0, a} * {32'b0, b}; {hi, lo} = u; end
            lat = 33;
        end else begin
            if (s) begin q = sa / sbv; r = sa % sbv; lo = q[31:0]; hi = r[31:0]; end
            else   begin lo = a / b; hi = a % b; end
            lat = 65;
        end
        if (s) lat = lat + 1;
    endfunction

    // Monitor: pops the scoreboard on every done pulse; HI/LO must stay frozen while busy.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("alu_req_eq_busy", {63'b0, o_alu_req}, {63'b0, o_busy});
            if (o_busy) chk("hilo_stable_busy", {o_hi, o_lo}, {m_hi, m_lo});
            if (o_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result_hilo", {o_hi, o_lo}, {e.hi, e.lo});
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    m_hi = e.hi;
                    m_lo = e.lo;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge i_clk);
        if (sb.size() != 0) begin
            chk("idle_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic issue(input bit op, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        wait_idle();
        model(op, sgn, a, b, e.hi, e.lo, lat);
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        i_start = 1'b1; i_op = op; i_op_signed = sgn; i_a = a; i_b = b;
        @(negedge i_clk);
        i_start = 1'b0; i_op_signed = 1'b0;
    endtask

    task automatic mt(input bit hwe, input bit lwe, input logic [31:0] d);
        logic [31:0] eh, el;
        wait_idle();
        eh = hwe ? d : m_hi;
        el = lwe ? d : m_lo;
        i_hi_we = hwe; i_lo_we = lwe; i_wdata = d;
        @(negedge i_clk);
        i_hi_we = 1'b0; i_lo_we = 1'b0;
        chk("mt_hi", {32'b0, o_hi}, {32'b0, eh});
        chk("mt_lo", {32'b0, o_lo}, {32'b0, el});
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [31:0] ra, rb;
        repeat (3) @(negedge i_clk);
        chk("rst_busy", {63'b0, o_busy}, 64'd0);
        chk("rst_done", {63'b0, o_done}, 64'd0);
        chk("rst_hilo", {o_hi, o_lo}, 64'd0);
        chk("rst_alu_ctrl", {60'b0, o_alu_ctrl}, 64'h4);
        chk("rst_alu_ab", {o_alu_a, o_alu_b}, 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'd1);
        issue(1'b1, 1'b0, 32'h0000_1234, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("div0_busy_low", {63'b0, o_busy}, 64'd0);
            @(negedge i_clk);
        end

        // Start and MTHI mid-multiply must be dropped.
        issue(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge i_clk);
        i_start = 1'b1; i_op = 1'b1; i_a = 32'd5; i_b = 32'd3;
        i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'hDEAD_BEEF;
        @(negedge i_clk);
        i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
        mt(1'b1, 1'b0, 32'hDEAD_BEEF);
        mt(1'b0, 1'b1, 32'hCAFE_F00D);
        mt(1'b1, 1'b1, 32'h0BAD_F00D);

        // Abort a divide with reset: no done, HI/LO cleared.
        issue(1'b1, 1'b0, 32'hFFFF_0000, 32'd3);
        repeat (9) @(negedge i_clk);
        i_rst = 1'b1;
        sb.delete();
        @(negedge i_clk);
        m_hi = '0; m_lo = '0;
        i_rst = 1'b0;
        chk("abort_busy", {63'b0, o_busy}, 64'd0);
        chk("abort_hilo", {o_hi, o_lo}, 64'd0);
        repeat (70) @(negedge i_clk);
        issue(1'b0, 1'b0, 32'd12345, 32'd6789);

        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3);
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb);
        end

        wait_idle();
        repeat (3) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
